// File: rtl/dna_port_sequencer.sv
// dna_port_sequencer
//   Drives the READ/SHIFT pins of the device-DNA primitive, which the parent
//   instantiates. The primitive is shared between NUM_REQ requesters through
//   round-robin arbitration. The serial DNA is captured into a right-aligned
//   96-bit register that every consumer can see. When AUTO_READ is set, one
//   internal read runs after reset release.
//
//   Optional feature macro: DNA_CMP_EN
//     defined   -> EXP_DNA parameter and registered dna_match output exist
//     undefined -> neither the port nor the comparator is built
//
//   Handshake: a requester raises req[i] and holds it. gnt[i] rises (one-hot)
//   and stays high for the whole read, including the DONE cycle. done[i]
//   pulses for exactly one cycle when dna_value has been updated. The
//   requester may drop req[i] after the done pulse, or at any point after the
//   grant; a read that has started always runs to completion.
//
//   fsm_state exposes the controller state for debug and checkers:
//   0 IDLE, 1 ARB, 2 LOAD, 3 SHIFT, 4 DONE.
module dna_port_sequencer #(
  parameter int          DNA_BITS  = 57,
  parameter int          NUM_REQ   = 2,
  parameter bit          AUTO_READ = 1'b1
`ifdef DNA_CMP_EN
  ,
  parameter logic [95:0] EXP_DNA   = 96'h0
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic [95:0]        dna_value,
  output logic               dna_valid,
  output logic               dna_read,
  output logic               dna_shift,
  output logic               dna_din,
  input  logic               dna_dout,
`ifdef DNA_CMP_EN
  output logic               dna_match,
`endif
  output logic [2:0]         fsm_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic               auto_pend;
  logic [CNT_W-1:0]   cnt;
  logic [94:0]        shift_reg;
  logic [95:0]        shift_nxt;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] hi_req;
  logic [PTR_W-1:0]   hi_idx;
  logic [PTR_W-1:0]   lo_idx;
  logic [PTR_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_onehot;

  // DIN is never used; the primitive is only ever read.
  assign dna_din   = 1'b0;
  assign fsm_state = state;

  // Next shift-register value: append the current DOUT bit, so the first bit
  // sampled ends up as the MSB of the captured value.
  assign shift_nxt = {shift_reg, dna_dout};

  // Round-robin pick. Search above the pointer first, then wrap to the
  // lowest index. In DONE the requester being served is masked out, so a
  // different waiting requester can be granted straight away.
  always_comb begin
    arb_req = (state == S_DONE) ? (req & ~gnt) : req;
    hi_req  = '0;
    hi_idx  = '0;
    lo_idx  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      hi_req[j] = arb_req[j] && (j > int'(ptr));
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (arb_req[j]) lo_idx = PTR_W'(j);
      if (hi_req[j])  hi_idx = PTR_W'(j);
    end
    arb_idx    = (|hi_req) ? hi_idx : lo_idx;
    arb_onehot = NUM_REQ'(1) << arb_idx;
  end

  // Controller. Each output register is loaded on the edge that enters the
  // state the output belongs to, so every output is valid during that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= PTR_W'(NUM_REQ - 1);
      auto_pend <= AUTO_READ;
      cnt       <= '0;
      shift_reg <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      dna_value <= '0;
      dna_valid <= 1'b0;
      dna_read  <= 1'b0;
      dna_shift <= 1'b0;
`ifdef DNA_CMP_EN
      dna_match <= 1'b0;
`endif
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (auto_pend) begin
            // Internal read: no grant, so no done pulse is issued at the end.
            auto_pend <= 1'b0;
            busy      <= 1'b1;
            dna_read  <= 1'b1;
            state     <= S_LOAD;
          end else if (|arb_req) begin
            gnt   <= arb_onehot;
            ptr   <= arb_idx;
            busy  <= 1'b1;
            state <= S_ARB;
          end
        end
        S_ARB: begin
          if ((req & gnt) == '0) begin
            // The winner withdrew before the read started.
            gnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            dna_read <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          dna_read  <= 1'b0;
          dna_shift <= 1'b1;
          cnt       <= '0;
          shift_reg <= '0;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          shift_reg <= shift_nxt[94:0];
          if (cnt == CNT_W'(DNA_BITS - 1)) begin
            dna_shift <= 1'b0;
            dna_value <= shift_nxt;
            dna_valid <= 1'b1;
            done      <= gnt;
`ifdef DNA_CMP_EN
            dna_match <= (shift_nxt == EXP_DNA);
`endif
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (|arb_req) begin
            gnt   <= arb_onehot;
            ptr   <= arb_idx;
            state <= S_ARB;
          end else begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          busy      <= 1'b0;
          dna_read  <= 1'b0;
          dna_shift <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
